riscv_cache_flush_ctrl: RTL and testbench

//  Sequencer for cache-wide flush (write back dirty lines, then invalidate) or invalidate-only.

---
 rtl/riscv_cache_flush_ctrl.sv | 95 +++++++++
 tb/tb_riscv_cache_flush_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_cache_flush_ctrl.sv
// riscv_cache_flush_ctrl: walks every cache set, writes back valid+dirty ways, then invalidates the set.
package riscv_cache_pkg;
  function automatic int no_of_sets(input int size_kb, input int block_bits, input int ways);
    return (size_kb * 1024 * 8) / (block_bits * ways);
  endfunction
  function automatic int no_of_index_bits(input int sets);
    return $clog2(sets);
  endfunction
endpackage

module riscv_cache_flush_ctrl
  import riscv_cache_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SIZE       = 64,
  parameter int BLOCK_SIZE = XLEN,
  parameter int WAYS       = 2,
  localparam int SETS      = no_of_sets(SIZE, BLOCK_SIZE, WAYS),
  localparam int IDX_BITS  = no_of_index_bits(SETS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_req_i,
  input  logic                inv_only_i,
  output logic                flush_busy_o,
  output logic                flush_done_o,
  output logic [IDX_BITS-1:0] tag_idx_o,
  output logic                tag_rd_o,
  input  logic [WAYS-1:0]     way_valid_i,
  input  logic [WAYS-1:0]     way_dirty_i,
  output logic                wb_req_o,
  output logic [IDX_BITS-1:0] wb_idx_o,
  output logic [WAYS-1:0]     wb_way_o,
  input  logic                wb_ack_i,
  output logic                inv_we_o,
  output logic [WAYS-1:0]     inv_way_o
);
  typedef enum logic [2:0] {IDLE, READ, CHECK, WB, INV, DONE} state_e;
  state_e state_q, state_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [WAYS-1:0] pend_q, pend_d, low_bit;
  logic inv_only_q, inv_only_d, last_set;
  assign low_bit  = pend_q & -pend_q;
  assign last_set = idx_q == IDX_BITS'(SETS - 1);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pend_q     <= '0;
      inv_only_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      inv_only_q <= inv_only_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    inv_only_d = inv_only_q;
    case (state_q)
      IDLE: if (flush_req_i) begin
        state_d    = READ;
        idx_d      = '0;
        inv_only_d = inv_only_i;
      end
      READ: state_d = CHECK;
      CHECK: begin
        pend_d  = way_valid_i & way_dirty_i & {WAYS{~inv_only_q}};
        state_d = |pend_d ? WB : INV;
      end
      WB: if (wb_ack_i) begin
        pend_d  = pend_q & ~low_bit;
        state_d = |pend_d ? WB : INV;
      end
      INV: begin
        state_d = last_set ? DONE : READ;
        idx_d   = last_set ? idx_q : idx_q + IDX_BITS'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign flush_busy_o = state_q != IDLE;
  assign flush_done_o = state_q == DONE;
  assign tag_idx_o    = state_q == IDLE ? '0 : idx_q;
  assign tag_rd_o     = state_q == READ;
  assign wb_req_o     = state_q == WB;
  assign wb_idx_o     = wb_req_o ? idx_q : '0;
  assign wb_way_o     = wb_req_o ? low_bit : '0;
  assign inv_we_o     = state_q == INV;
  assign inv_way_o    = {WAYS{inv_we_o}};
endmodule

// File: tb/tb_riscv_cache_flush_ctrl.sv
// tb_riscv_cache_flush_ctrl: randomized flush walks scored against an event-list model of the controller.
module tb_riscv_cache_flush_ctrl;
  localparam int SETS = 32;
  logic clk_i = 1'b0, rst_i = 1'b1, flush_req_i = 1'b0, inv_only_i = 1'b0, wb_ack_i = 1'b0;
  logic [1:0] way_valid_i = '0, way_dirty_i = '0;
  logic flush_busy_o, flush_done_o, tag_rd_o, wb_req_o, inv_we_o;
  logic [4:0] tag_idx_o, wb_idx_o;
  logic [1:0] wb_way_o, inv_way_o;

  riscv_cache_flush_ctrl #(.SIZE(1), .BLOCK_SIZE(128), .WAYS(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_req_i(flush_req_i), .inv_only_i(inv_only_i),
    .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o), .tag_idx_o(tag_idx_o),
    .tag_rd_o(tag_rd_o), .way_valid_i(way_valid_i), .way_dirty_i(way_dirty_i),
    .wb_req_o(wb_req_o), .wb_idx_o(wb_idx_o), .wb_way_o(wb_way_o), .wb_ack_i(wb_ack_i),
    .inv_we_o(inv_we_o), .inv_way_o(inv_way_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum int {EV_WB, EV_INV, EV_DONE} ev_kind_e;
  typedef struct {ev_kind_e k; int idx; logic [1:0] way;} ev_t;
  ev_t exp_q[$];
  logic [1:0] vmem[SETS], dmem[SETS];
  int cyc = 0, passed = 0, total = 0;
  int acc_cyc = 0, wb_extra = 0, ack_lo = 0, ack_hi = 3;
  bit done_seen = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic pop_check(input string nm, input ev_kind_e k, input int idx, input logic [1:0] way);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL %s: unexpected event idx %0d way %0d, expected none (cycle %0d)", nm, idx, way, cyc);
    end else begin
      e = exp_q.pop_front();
      check({nm, "_kind"}, k, e.k);
      check({nm, "_idx"}, idx, e.idx);
      check({nm, "_way"}, way, e.way);
    end
  endtask

  // Tag memory: real contents only in the cycle after a read strobe, garbage otherwise.
  bit rd_p = 1'b0;
  logic [4:0] idx_p = '0;
  always @(negedge clk_i) begin
    if (rd_p) begin
      way_valid_i = vmem[idx_p];
      way_dirty_i = dmem[idx_p];
    end else begin
      way_valid_i = 2'($urandom);
      way_dirty_i = 2'($urandom);
    end
    rd_p  = tag_rd_o;
    idx_p = tag_idx_o;
  end

  int ack_cnt = -1;
  always @(negedge clk_i) begin
    wb_ack_i = 1'b0;
    if (rst_i || !wb_req_o) ack_cnt = -1;
    else begin
      if (ack_cnt < 0) begin
        ack_cnt = int'($urandom_range(ack_hi, ack_lo));
        wb_extra += ack_cnt + 1;
      end
      if (ack_cnt == 0) begin
        wb_ack_i = 1'b1;
        ack_cnt  = -1;
      end else ack_cnt--;
    end
  end

  logic p_req = 1'b0, p_ack = 1'b0;
  logic [4:0] p_idx = '0;
  logic [1:0] p_way = '0;
  always begin
    @(negedge clk_i);
    #1;
    if (rst_i) p_req = 1'b0;
    else begin
      if (wb_req_o && p_req && !p_ack) begin
        check("wb_hold_idx", wb_idx_o, p_idx);
        check("wb_hold_way", wb_way_o, p_way);
      end
      if (wb_req_o && wb_ack_i) pop_check("wb", EV_WB, int'(wb_idx_o), wb_way_o);
      if (inv_we_o) pop_check("inv", EV_INV, int'(tag_idx_o), inv_way_o);
      if (flush_done_o) begin
        pop_check("done", EV_DONE, int'(tag_idx_o), 2'b00);
        check("done_cycle", cyc, acc_cyc + 3 * SETS + 1 + wb_extra);
        check("done_busy", flush_busy_o, 1);
        done_seen = 1'b1;
      end
      p_req = wb_req_o;
      p_ack = wb_ack_i;
      p_idx = wb_idx_o;
      p_way = wb_way_o;
    end
  end

  task automatic start_flush(input bit inv);
    ev_t e;
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < 2; w++)
        if (vmem[s][w] && dmem[s][w] && !inv) begin
          e = '{k: EV_WB, idx: s, way: 2'(1 << w)};
          exp_q.push_back(e);
        end
      e = '{k: EV_INV, idx: s, way: 2'b11};
      exp_q.push_back(e);
    end
    e = '{k: EV_DONE, idx: SETS - 1, way: 2'b00};
    exp_q.push_back(e);
    wb_extra  = 0;
    done_seen = 1'b0;
    @(negedge clk_i);
    flush_req_i = 1'b1;
    inv_only_i  = inv;
    acc_cyc     = cyc;
    @(negedge clk_i);
    flush_req_i = 1'b0;
    inv_only_i  = ~inv;
    #1 check("start_busy_rd_idx0", {flush_busy_o, tag_rd_o, tag_idx_o}, {1'b1, 1'b1, 5'd0});
  endtask

  task automatic wait_done(input int mid);
    int n = 0;
    while (!done_seen && n < 2000) begin
      @(negedge clk_i);
      flush_req_i = (n == mid);
      inv_only_i  = 1'($urandom);
      n++;
    end
    flush_req_i = 1'b0;
    if (!done_seen) begin
      total++;
      $display("FAIL done_timeout: no flush_done_o within %0d cycles", n);
    end else begin
      #1 check("idle_after_done", {flush_busy_o, tag_idx_o}, 0);
      check("queue_drained", exp_q.size(), 0);
    end
  endtask

  task automatic fill(input logic [1:0] v, input logic [1:0] d, input bit rnd);
    for (int s = 0; s < SETS; s++) begin
      vmem[s] = rnd ? 2'($urandom) : v;
      dmem[s] = rnd ? 2'($urandom) : d;
    end
  endtask

  initial begin
    int n;
    fill(2'b00, 2'b00, 1'b0);
    repeat (3) @(negedge clk_i);
    #1 check("reset_outputs", {flush_busy_o, flush_done_o, tag_idx_o, tag_rd_o, wb_req_o, wb_idx_o,
                               wb_way_o, inv_we_o, inv_way_o}, 0);
    rst_i = 1'b0;
    // all valid, none dirty
    fill(2'b11, 2'b00, 1'b0);
    start_flush(1'b0);
    wait_done(-1);
    // single writeback, slow ack
    fill(2'b11, 2'b00, 1'b0);
    dmem[5] = 2'b10;
    ack_lo = 4; ack_hi = 4;
    start_flush(1'b0);
    wait_done(-1);
    // both ways dirty in one set
    fill(2'b00, 2'b00, 1'b0);
    vmem[7] = 2'b11; dmem[7] = 2'b11;
    ack_lo = 0; ack_hi = 3;
    start_flush(1'b0);
    wait_done(-1);
    // invalidate only over a fully dirty cache
    fill(2'b11, 2'b11, 1'b0);
    start_flush(1'b1);
    wait_done(-1);
    // reset while a writeback is outstanding at set 10
    fill(2'b00, 2'b00, 1'b0);
    vmem[10] = 2'b01; dmem[10] = 2'b01;
    ack_lo = 50; ack_hi = 50;
    start_flush(1'b0);
    n = 0;
    while (!wb_req_o && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("wb_at_set10", {wb_req_o, wb_idx_o}, {1'b1, 5'd10});
    rst_i = 1'b1;
    @(negedge clk_i);
    #1 check("reset_midwalk_outputs", {flush_busy_o, flush_done_o, tag_idx_o, tag_rd_o, wb_req_o,
                                       wb_idx_o, wb_way_o, inv_we_o, inv_way_o}, 0);
    rst_i = 1'b0;
    exp_q.delete();
    ack_lo = 0; ack_hi = 3;
    start_flush(1'b0);
    wait_done(-1);
    // mid-walk request ignored; invalid-but-dirty set never written back
    fill(2'b00, 2'b00, 1'b1);
    vmem[3] = 2'b00; dmem[3] = 2'b11;
    start_flush(1'b0);
    wait_done(40);
    repeat (110) @(negedge clk_i);
    // random contents and modes
    for (int t = 0; t < 4; t++) begin
      fill(2'b00, 2'b00, 1'b1);
      start_flush($urandom_range(3, 0) == 0);
      wait_done(int'($urandom_range(80, 5)));
      repeat (int'($urandom_range(4, 1))) @(negedge clk_i);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
